// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle controller: instruction encodings,
// ALU operation codes and the controller state type.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;
  localparam logic [3:0] ALU_SRAV = 4'd13;

  function automatic logic is_alu_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU) ||
           (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface multicycle_controller_if #(
  parameter int unsigned ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         func;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               Regwrite;
  logic               AluSrcA;
  logic               signed_imm;
  logic               DataC;
  logic [1:0]         RegDst;
  logic [1:0]         AluSrcB;
  logic [1:0]         PCSrc;
  logic [ALUOP_W-1:0] AluOperation;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  opcode, func, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, Regwrite, AluSrcA,
           signed_imm, DataC, RegDst, AluSrcB, PCSrc, AluOperation, instr_done, illegal_op
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, Regwrite, AluSrcA,
           signed_imm, DataC, RegDst, AluSrcB, PCSrc, AluOperation, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational opcode/func -> ALU operation code, flagging unsupported encodings.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);

  logic [3:0] code;

  always_comb begin
    code    = ALU_AND;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU: code = ALU_ADD;
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:          code = ALU_AND;
          FN_OR:           code = ALU_OR;
          FN_XOR:          code = ALU_XOR;
          FN_NOR:          code = ALU_NOR;
          FN_SLT, FN_SLTU: code = ALU_SLT;
          FN_SLL:          code = ALU_SLL;
          FN_SRL:          code = ALU_SRL;
          FN_SRA:          code = ALU_SRA;
          FN_SLLV:         code = ALU_SLLV;
          FN_SRLV:         code = ALU_SRLV;
          FN_SRAV:         code = ALU_SRAV;
          FN_JR:           code = ALU_AND;
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: code = ALU_ADD;
      OP_SLTI, OP_SLTIU:               code = ALU_SLT;
      OP_ANDI:                         code = ALU_AND;
      OP_ORI:                          code = ALU_OR;
      OP_XORI:                         code = ALU_XOR;
      OP_LUI:                          code = ALU_LUI;
      OP_BEQ, OP_BNE:                  code = ALU_SUB;
      OP_J, OP_JAL:                    code = ALU_AND;
      default:                         illegal = 1'b1;
    endcase
  end

  assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes for each captured instruction.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master bus
);

  state_t             state;
  logic [5:0]         op_q;
  logic [5:0]         fn_q;
  logic               ready;
  logic [5:0]         dec_opcode;
  logic [5:0]         dec_func;
  logic [ALUOP_W-1:0] dec_op;
  logic               dec_illegal;
  logic               is_r, is_jr, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;

  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // DECODE judges legality on the live IR fields; later states see only the captured copy.
  assign dec_opcode = (state == DECODE) ? bus.opcode : op_q;
  assign dec_func   = (state == DECODE) ? bus.func   : fn_q;

  alu_decoder #(.ALUOP_W(ALUOP_W)) u_alu_decoder (
    .opcode  (dec_opcode),
    .func    (dec_func),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  assign is_r   = (op_q == OP_RTYPE);
  assign is_jr  = is_r && (fn_q == FN_JR);
  assign is_imm = is_alu_imm(op_q);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_bne = (op_q == OP_BNE);
  assign is_j   = (op_q == OP_J);
  assign is_jal = (op_q == OP_JAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= '0;
      fn_q  <= '0;
    end else begin
      case (state)
        FETCH: if (ready) state <= DECODE;
        DECODE: begin
          op_q  <= bus.opcode;
          fn_q  <= bus.func;
          state <= dec_illegal ? FETCH : EXECUTE;
        end
        EXECUTE: begin
          if (is_lw || is_sw)                 state <= MEMORY;
          else if ((is_r && !is_jr) || is_imm) state <= WRITEBACK;
          else                                 state <= FETCH;
        end
        MEMORY: if (ready) state <= is_lw ? WRITEBACK : FETCH;
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

  // Strobes are decoded from state; FETCH/MEMORY handshakes and branch outcome follow
  // mem_ready/zero within the cycle, and reset forces everything low at once.
  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.Regwrite     = 1'b0;
    bus.AluSrcA      = 1'b0;
    bus.signed_imm   = 1'b0;
    bus.DataC        = 1'b0;
    bus.RegDst       = 2'b00;
    bus.AluSrcB      = 2'b00;
    bus.PCSrc        = 2'b00;
    bus.AluOperation = '0;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.MemRead      = 1'b1;
          bus.AluSrcB      = 2'b01;
          bus.AluOperation = ALUOP_W'(ALU_ADD);
          bus.IRWrite      = ready;
          bus.PCWrite      = ready;
        end
        DECODE: begin
          bus.AluSrcB    = 2'b11;
          bus.signed_imm = 1'b1;
          bus.illegal_op = dec_illegal;
          bus.instr_done = dec_illegal;
        end
        EXECUTE: begin
          bus.AluOperation = dec_op;
          if (is_lw || is_sw) begin
            bus.AluSrcA    = 1'b1;
            bus.AluSrcB    = 2'b10;
            bus.signed_imm = 1'b1;
          end else if (is_jr) begin
            bus.PCWrite    = 1'b1;
            bus.PCSrc      = 2'b11;
            bus.instr_done = 1'b1;
          end else if (is_r) begin
            bus.AluSrcA = 1'b1;
          end else if (is_imm) begin
            bus.AluSrcA    = 1'b1;
            bus.AluSrcB    = 2'b10;
            bus.signed_imm = (op_q == OP_ADDI) || (op_q == OP_SLTI);
          end else if (is_beq || is_bne) begin
            bus.AluSrcA    = 1'b1;
            bus.PCSrc      = 2'b01;
            bus.PCWrite    = is_beq ? bus.zero : !bus.zero;
            bus.instr_done = 1'b1;
          end else if (is_j || is_jal) begin
            bus.PCWrite    = 1'b1;
            bus.PCSrc      = 2'b10;
            bus.instr_done = 1'b1;
            bus.Regwrite   = is_jal;
            bus.RegDst     = is_jal ? 2'b10 : 2'b00;
            bus.DataC      = is_jal;
          end
        end
        MEMORY: begin
          bus.IorD       = 1'b1;
          bus.MemRead    = is_lw;
          bus.MemWrite   = is_sw;
          bus.instr_done = is_sw && ready;
        end
        WRITEBACK: begin
          bus.Regwrite   = 1'b1;
          bus.RegDst     = is_r ? 2'b01 : 2'b00;
          bus.MemtoReg   = is_lw;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction phase-list model, plus directed cases.
module tb_multicycle_controller;

  typedef enum int {K_R, K_JR, K_IMM, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

  typedef struct {
    kind_t      k;
    logic [3:0] alu;
    logic       simm;
  } info_t;

  typedef struct packed {
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, Regwrite, AluSrcA, signed_imm, DataC;
    logic [1:0] RegDst, AluSrcB, PCSrc;
    logic [3:0] AluOperation;
    logic       instr_done, illegal_op;
  } outs_t;

  localparam logic [5:0] RFN [17] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                                      6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8};
  localparam logic [5:0] IOP [15] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
                                      6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd63};

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    failures = 0;
  outs_t dut_o;
  outs_t seen [64];
  outs_t last_pre;

  multicycle_controller_if #(.ALUOP_W(4)) bus ();

  multicycle_controller #(.ALUOP_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign dut_o = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                  bus.Regwrite, bus.AluSrcA, bus.signed_imm, bus.DataC, bus.RegDst, bus.AluSrcB,
                  bus.PCSrc, bus.AluOperation, bus.instr_done, bus.illegal_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic info_t lookup(input logic [5:0] op, input logic [5:0] fn);
    info_t r;
    r.k = K_ILL; r.alu = 4'd0; r.simm = 1'b0;
    case (op)
      6'd0: begin
        r.k = K_R;
        case (fn)
          6'd32, 6'd33: r.alu = 4'd2;
          6'd34, 6'd35: r.alu = 4'd3;
          6'd36: r.alu = 4'd0;
          6'd37: r.alu = 4'd1;
          6'd38: r.alu = 4'd6;
          6'd39: r.alu = 4'd5;
          6'd42, 6'd43: r.alu = 4'd4;
          6'd0: r.alu = 4'd8;
          6'd2: r.alu = 4'd9;
          6'd3: r.alu = 4'd10;
          6'd4: r.alu = 4'd11;
          6'd6: r.alu = 4'd12;
          6'd7: r.alu = 4'd13;
          6'd8: r.k = K_JR;
          default: r.k = K_ILL;
        endcase
      end
      6'd8:  begin r.k = K_IMM; r.alu = 4'd2; r.simm = 1'b1; end
      6'd9:  begin r.k = K_IMM; r.alu = 4'd2; end
      6'd10: begin r.k = K_IMM; r.alu = 4'd4; r.simm = 1'b1; end
      6'd11: begin r.k = K_IMM; r.alu = 4'd4; end
      6'd12: begin r.k = K_IMM; r.alu = 4'd0; end
      6'd13: begin r.k = K_IMM; r.alu = 4'd1; end
      6'd14: begin r.k = K_IMM; r.alu = 4'd6; end
      6'd15: begin r.k = K_IMM; r.alu = 4'd7; end
      6'd35: begin r.k = K_LW;  r.alu = 4'd2; r.simm = 1'b1; end
      6'd43: begin r.k = K_SW;  r.alu = 4'd2; r.simm = 1'b1; end
      6'd4:  begin r.k = K_BEQ; r.alu = 4'd3; end
      6'd5:  begin r.k = K_BNE; r.alu = 4'd3; end
      6'd2:  r.k = K_J;
      6'd3:  r.k = K_JAL;
      default: r.k = K_ILL;
    endcase
    return r;
  endfunction

  function automatic string phases_of(input kind_t k);
    case (k)
      K_R, K_IMM, K_LW: return (k == K_LW) ? "FDEMW" : "FDEW";
      K_SW:             return "FDEM";
      K_ILL:            return "FD";
      default:          return "FDE";
    endcase
  endfunction

  function automatic outs_t exp_out(input info_t in, input byte ph, input logic rdy, input logic z);
    outs_t o;
    o = '0;
    case (ph)
      "F": begin
        o.MemRead = 1'b1; o.AluSrcB = 2'b01; o.AluOperation = 4'd2;
        o.IRWrite = rdy;  o.PCWrite = rdy;
      end
      "D": begin
        o.AluSrcB = 2'b11; o.signed_imm = 1'b1;
        o.illegal_op = (in.k == K_ILL); o.instr_done = (in.k == K_ILL);
      end
      "E": begin
        o.AluOperation = in.alu;
        case (in.k)
          K_R:                 o.AluSrcA = 1'b1;
          K_IMM, K_LW, K_SW:   begin o.AluSrcA = 1'b1; o.AluSrcB = 2'b10; o.signed_imm = in.simm; end
          K_BEQ, K_BNE: begin
            o.AluSrcA = 1'b1; o.PCSrc = 2'b01; o.instr_done = 1'b1;
            o.PCWrite = (in.k == K_BEQ) ? z : !z;
          end
          K_J:   begin o.PCWrite = 1'b1; o.PCSrc = 2'b10; o.instr_done = 1'b1; end
          K_JAL: begin
            o.PCWrite = 1'b1; o.PCSrc = 2'b10; o.instr_done = 1'b1;
            o.Regwrite = 1'b1; o.RegDst = 2'b10; o.DataC = 1'b1;
          end
          K_JR:  begin o.PCWrite = 1'b1; o.PCSrc = 2'b11; o.instr_done = 1'b1; end
          default: ;
        endcase
      end
      "M": begin
        o.IorD = 1'b1;
        o.MemRead = (in.k == K_LW);
        o.MemWrite = (in.k == K_SW);
        o.instr_done = (in.k == K_SW) && rdy;
      end
      "W": begin
        o.Regwrite = 1'b1; o.RegDst = (in.k == K_R) ? 2'b01 : 2'b00;
        o.MemtoReg = (in.k == K_LW); o.instr_done = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Entered and left at 1 time unit after a rising edge. zm: 0/1 force zero, 2 random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms,
                           input int zm, input int abort_cyc, output int ncyc);
    info_t inf;
    string seq;
    int    idx, fw, mw;
    bit    done;
    byte   ph;
    logic  rdy;
    outs_t e;
    inf = lookup(op, fn);
    seq = phases_of(inf.k);
    idx = 0; fw = fs; mw = ms; done = 1'b0; ncyc = 0;
    while (!done && ncyc < 64) begin
      ph = seq[idx];
      if (ph == "F")      rdy = (fw == 0);
      else if (ph == "M") rdy = (mw == 0);
      else                rdy = 1'($urandom);
      bus.mem_ready = rdy;
      bus.zero      = (zm == 2) ? 1'($urandom) : 1'(zm);
      bus.opcode    = (ph == "D") ? op : 6'($urandom);
      bus.func      = (ph == "D") ? fn : 6'($urandom);
      e = exp_out(inf, ph, rdy, bus.zero);
      if (ncyc == abort_cyc) begin
        #2;
        last_pre = dut_o;
        chk("pre_reset_outputs", dut_o, e);
        rst = 1'b1;
        #1 chk("reset_async_outputs_zero", dut_o, '0);
        @(negedge clk) chk("reset_held_outputs_zero", dut_o, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
        seen[ncyc] = dut_o;
        chk($sformatf("k%0d_phase_%s_cyc%0d", inf.k, string'(ph), ncyc), dut_o, e);
        ncyc++;
        if (ph == "F" && !rdy)      fw--;
        else if (ph == "M" && !rdy) mw--;
        else begin
          idx++;
          if (idx == seq.len()) done = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("instr_cycle_budget", 32'(ncyc), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    logic [5:0] op, fn;
    bus.opcode = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #1 chk("reset_outputs_zero_t0", dut_o, '0);
    @(negedge clk) chk("reset_outputs_zero_c1", dut_o, '0);
    bus.mem_ready = 1'b1;
    @(negedge clk) chk("reset_outputs_zero_c2", dut_o, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(6'd0, 6'd32, 0, 0, 2, -1, n);
    chk("add_cycles", 32'(n), 32'd4);
    chk("add_first_fetch_memread", 32'(seen[0].MemRead), 32'd1);
    chk("add_exec_aluop", 32'(seen[2].AluOperation), 32'd2);
    chk("add_wb_regwrite", 32'(seen[3].Regwrite), 32'd1);
    chk("add_wb_regdst", 32'(seen[3].RegDst), 32'd1);
    chk("add_wb_done", 32'(seen[3].instr_done), 32'd1);

    run_instr(6'd35, 6'd0, 0, 3, 2, -1, n);
    chk("lw_stall_cycles", 32'(n), 32'd8);
    for (int i = 3; i < 7; i++) chk($sformatf("lw_mem_c%0d", i), {30'd0, seen[i].MemRead, seen[i].IorD}, 32'd3);
    chk("lw_wb_memtoreg", 32'(seen[7].MemtoReg), 32'd1);

    run_instr(6'd4, 6'd0, 0, 0, 1, -1, n);
    chk("beq_cycles", 32'(n), 32'd3);
    chk("beq_z1_pcwrite", 32'(seen[2].PCWrite), 32'd1);
    chk("beq_pcsrc", 32'(seen[2].PCSrc), 32'd1);
    run_instr(6'd5, 6'd0, 1, 0, 1, -1, n);
    chk("bne_cycles_with_fetch_stall", 32'(n), 32'd4);
    chk("bne_z1_pcwrite", 32'(seen[3].PCWrite), 32'd0);
    chk("bne_done", 32'(seen[3].instr_done), 32'd1);

    run_instr(6'd3, 6'd0, 0, 0, 2, -1, n);
    chk("jal_exec", {seen[2].PCWrite, seen[2].PCSrc, seen[2].Regwrite, seen[2].RegDst, seen[2].DataC},
        {25'd0, 7'b1_10_1_10_1});
    run_instr(6'd0, 6'd8, 0, 0, 2, -1, n);
    chk("jr_exec", {seen[2].PCSrc, seen[2].Regwrite}, {29'd0, 3'b11_0});

    run_instr(6'd63, 6'd0, 0, 0, 2, -1, n);
    chk("illegal_cycles", 32'(n), 32'd2);
    chk("illegal_pulse", {seen[1].illegal_op, seen[1].instr_done}, 32'd3);
    chk("illegal_no_writes", {seen[1].PCWrite, seen[1].Regwrite, seen[1].MemWrite}, 32'd0);

    run_instr(6'd43, 6'd0, 0, 3, 2, 4, n);
    chk("sw_memwrite_before_reset", 32'(last_pre.MemWrite), 32'd1);
    run_instr(6'd9, 6'd0, 0, 0, 2, -1, n);
    chk("post_reset_fetch_memread", 32'(seen[0].MemRead), 32'd1);

    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 1);
      if (k == 0) begin
        op = 6'd0;
        fn = ($urandom_range(0, 9) == 0) ? 6'd63 : RFN[$urandom_range(0, 16)];
      end else begin
        op = IOP[$urandom_range(0, 14)];
        fn = 6'($urandom);
      end
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
